// File: rtl/uart_receiver.sv
// 8N1 UART receiver, OVERSAMPLE clk cycles per bit, LSB first.
// Optional input synchroniser enabled by defining UART_RX_SYNC_EN.
module uart_receiver #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_in,
  output logic [DATA_BITS-1:0] par_data,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_par_data;
  logic                 r_rx_done;
  logic                 r_frame_err;
  logic                 r_prev_line;
  logic                 w_line;
  logic                 w_mid;
  logic                 w_bit_end;
  logic                 w_last_bit;

`ifdef UART_RX_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  // Two-flop synchroniser; idles high so reset does not fake a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= data_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_line = r_sync2;
`else
  assign w_line = data_in;
`endif

  assign w_mid      = (r_cnt == CW'(OVERSAMPLE / 2 - 1));
  assign w_bit_end  = (r_cnt == CW'(OVERSAMPLE - 1));
  assign w_last_bit = (r_bit_idx == IW'(DATA_BITS - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (r_prev_line && !w_line) w_state_next = S_START;
      S_START: if (w_mid) w_state_next = w_line ? S_IDLE : S_DATA;
      S_DATA:  if (w_bit_end && w_last_bit) w_state_next = S_STOP;
      S_STOP:  if (w_bit_end) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Counters, shift register, edge detector and registered output strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_par_data  <= '0;
      r_rx_done   <= 1'b0;
      r_frame_err <= 1'b0;
      r_prev_line <= 1'b1;
    end else begin
      r_prev_line <= w_line;
      r_rx_done   <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt     <= '0;
          r_bit_idx <= '0;
        end
        S_START: begin
          if (w_mid) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_cnt              <= '0;
            r_shift[r_bit_idx] <= w_line;
            r_bit_idx          <= w_last_bit ? '0 : r_bit_idx + IW'(1);
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (w_line) begin
              r_par_data <= r_shift;
              r_rx_done  <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign par_data  = r_par_data;
  assign rx_done   = r_rx_done;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: table of frames, hand-written
// corner sequences and randomized frames checked against an event schedule.
module tb_uart_receiver;

`ifdef UART_RX_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam int LAT = 153 + SYNC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       data_in = 1'b1;
  logic [7:0] par_data;
  logic       rx_done;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: expected strobe per cycle (1 = rx_done, 2 = frame_err) and byte.
  int         ev_type[int];
  logic [7:0] ev_val[int];
  logic [7:0] exp_par = 8'h00;
  int         n_sched = 0;
  int         n_hit = 0;

  // Observed pulse statistics, cleared per table entry.
  int p_done = 0;
  int p_err = 0;
  int p_cyc = 0;
  int last_t = 0;

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         gap;
    logic [7:0] exp_par;
    int         exp_done;
    int         exp_err;
  } vec_t;

  vec_t vecs[5];
  int   pulse_at[5];

  uart_receiver #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .par_data (par_data),
    .rx_done  (rx_done),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive after posedge, check strobes at negedge.
  task automatic step(input logic v, input logic r);
    int et;
    @(posedge clk);
    #1;
    data_in = v;
    rst = r;
    cyc++;
    @(negedge clk);
    et = ev_type.exists(cyc) ? ev_type[cyc] : 0;
    if (rx_done === 1'b1 || frame_err === 1'b1 || et != 0) begin
      checks++;
      if (rx_done !== (et == 1) || frame_err !== (et == 2)) begin
        failures++;
        $display("FAIL strobe: rx_done=%b frame_err=%b expected type %0d (cycle %0d)",
                 rx_done, frame_err, et, cyc);
      end else if (et == 1 && par_data !== ev_val[cyc]) begin
        failures++;
        $display("FAIL par_data: got %h expected %h (cycle %0d)", par_data, ev_val[cyc], cyc);
      end else if (et == 2 && par_data !== exp_par) begin
        failures++;
        $display("FAIL par_hold: got %h expected %h (cycle %0d)", par_data, exp_par, cyc);
      end else begin
        n_hit++;
      end
      if (et == 1) exp_par = ev_val[cyc];
      if (rx_done === 1'b1) begin p_done++; p_cyc = cyc; end
      if (frame_err === 1'b1) begin p_err++; p_cyc = cyc; end
    end
  endtask

  // Serialise one 8N1 frame and schedule its expected outcome.
  task automatic send_frame(input logic [7:0] d, input bit ok, input int gap);
    last_t = cyc + 1;
    ev_type[last_t + LAT] = ok ? 1 : 2;
    ev_val[last_t + LAT] = d;
    n_sched++;
    repeat (16) step(1'b0, 1'b0);
    for (int b = 0; b < 8; b++) repeat (16) step(d[b], 1'b0);
    repeat (16) step(ok, 1'b0);
    repeat (gap) step(1'b1, 1'b0);
  endtask

  initial begin
    logic [7:0] rd;
    logic [7:0] f5a;
    bit         rok;
    int         c0;
    logic       fb;

    vecs[0] = '{8'hA5, 1'b1, 5,  8'hA5, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 0,  8'h00, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 10, 8'hFF, 1, 0};
    vecs[3] = '{8'h3C, 1'b0, 10, 8'hFF, 0, 1};
    vecs[4] = '{8'h81, 1'b1, 3,  8'h81, 1, 0};

    // Reset and reset-state check.
    repeat (3) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    chk("reset_par", par_data, 8'h00);
    chk("reset_done", rx_done, 1'b0);
    chk("reset_err", frame_err, 1'b0);
    chk("reset_busy", busy, 1'b0);
    repeat (4) step(1'b1, 1'b0);

    // Table-driven frames.
    for (int i = 0; i < 5; i++) begin
      p_done = 0;
      p_err = 0;
      p_cyc = -1;
      send_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].gap);
      chk("tbl_done_count", p_done, vecs[i].exp_done);
      chk("tbl_err_count", p_err, vecs[i].exp_err);
      chk("tbl_par", par_data, vecs[i].exp_par);
      chk("tbl_latency", p_cyc - last_t, LAT);
      pulse_at[i] = p_cyc;
    end
    chk("back_to_back_spacing", pulse_at[2] - pulse_at[1], 160);

    // 4-cycle glitch: start aborts at the mid-bit sample.
    repeat (5) step(1'b1, 1'b0);
    c0 = cyc + 1;
    for (int k = 0; k <= 20; k++) begin
      step((k < 4) ? 1'b0 : 1'b1, 1'b0);
      if (cyc == c0 + 8 + SYNC) chk("glitch_busy_hi", busy, 1'b1);
      if (cyc == c0 + 9 + SYNC) chk("glitch_busy_lo", busy, 1'b0);
    end
    chk("glitch_par", par_data, 8'h81);

    // Bad stop bit followed by a break: no retrigger while low.
    send_frame(8'h3C, 1'b0, 0);
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 1'b0);
      chk("break_busy", busy, 1'b0);
    end
    chk("break_par", par_data, 8'h81);
    repeat (5) step(1'b1, 1'b0);
    send_frame(8'h96, 1'b1, 5);
    chk("after_break_par", par_data, 8'h96);

    // Reset in cycle 70 of a 0x5A frame.
    f5a = 8'h5A;
    for (int i = 0; i <= 70; i++) begin
      if (i < 16)       fb = 1'b0;
      else if (i < 144) fb = f5a[(i - 16) / 16];
      else              fb = 1'b1;
      step(fb, (i == 70) ? 1'b1 : 1'b0);
    end
    step(1'b1, 1'b0);
    exp_par = 8'h00;
    chk("midreset_busy", busy, 1'b0);
    chk("midreset_par", par_data, 8'h00);
    chk("midreset_done", rx_done, 1'b0);
    chk("midreset_err", frame_err, 1'b0);
    repeat (20) step(1'b1, 1'b0);
    send_frame(8'h81, 1'b1, 5);
    chk("post_reset_par", par_data, 8'h81);

    // Randomized frames against the event schedule.
    for (int n = 0; n < 12; n++) begin
      rd = 8'($urandom_range(0, 255));
      rok = ($urandom_range(0, 3) != 0);
      send_frame(rd, rok, rok ? $urandom_range(0, 20) : $urandom_range(1, 20));
    end
    repeat (170) step(1'b1, 1'b0);
    chk("all_events_matched", n_hit, n_sched);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
